mcycle_unit: RTL
================

MCYCLE_UNIT -- requirements
Module: mcycle_unit

Interface
REQ-001 Parameter: WIDTH, default 32, operand and result width in bits.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RESET  input  1  reset, synchronous and active-high.
REQ-004 Start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 MCycleOp  input  2  operation select: 00 signed mul, 01 unsigned mul, 10 signed div, 11 unsigned div.
REQ-006 Operand1  input  WIDTH  multiplicand or dividend.
REQ-007 Operand2  input  WIDTH  multiplier or divisor.
REQ-008 Result1  output  WIDTH  mul: product low word; div: quotient.
REQ-009 Result2  output  WIDTH  mul: product high word; div: remainder.
REQ-010 Busy  output  1  high while an operation is in progress.

Function
REQ-011 The unit SHALL have two states: IDLE and COMPUTING.
REQ-012 In IDLE with Start=1 at edge N, the unit SHALL capture Operand1, Operand2 and MCycleOp, enter COMPUTING, and drive Busy=1 from cycle N+1.
REQ-013 The unit SHALL perform exactly WIDTH iterations in COMPUTING, one per cycle: shift-add for mul, restoring shift-subtract for div.
REQ-014 Busy SHALL be high for exactly WIDTH cycles (N+1..N+WIDTH); in cycle N+WIDTH+1 the state SHALL be IDLE, Busy=0 and Result1/Result2 valid.
REQ-015 Result1/Result2 SHALL hold their last values until the next accepted Start completes; intermediate values SHALL NOT be visible on the outputs during COMPUTING.
REQ-016 Start, Operand and MCycleOp changes while Busy=1 SHALL be ignored.
REQ-017 Start=1 in the first IDLE cycle after completion SHALL be accepted with no dead cycle (back-to-back operations).
REQ-018 Signed ops SHALL operate on magnitudes and apply the sign at completion; the product SHALL be the full 2*WIDTH-bit two's-complement result.
REQ-019 Division SHALL truncate toward zero; the remainder SHALL take the sign of the dividend, with |remainder| < |divisor|.
REQ-020 Divide by zero SHALL take full latency and yield Result1 = all ones, Result2 = Operand1.
REQ-021 Signed division of the most negative value by -1 SHALL yield Result1 = most negative value, Result2 = 0.
REQ-022 All datapath arithmetic SHALL use WIDTH+1-bit intermediates so that no iteration loses a carry or borrow.

Reset
REQ-023 RESET=1 at any edge SHALL force IDLE, Busy=0, Result1=0, Result2=0 and clear all internal registers, including when applied mid-operation.
REQ-024 When RESET and Start are both high, RESET SHALL win and the Start SHALL be discarded.
REQ-025 After RESET deasserts, the first Start SHALL be accepted in the following cycle.

Verification
REQ-026 Unsigned mul 0xFFFFFFFF x 0xFFFFFFFF -> after 32 Busy cycles: Result2=0xFFFFFFFE, Result1=0x00000001.
REQ-027 Signed mul -3 (0xFFFFFFFD) x 7 -> Result2=0xFFFFFFFF, Result1=0xFFFFFFEB; signed div -7/2 -> Result1=0xFFFFFFFD, Result2=0xFFFFFFFF.
REQ-028 Unsigned div 100/0 -> Result1=0xFFFFFFFF, Result2=0x00000064; signed div 0x80000000/0xFFFFFFFF -> Result1=0x80000000, Result2=0.
REQ-029 Start pulsed again at Busy cycle 5 with new operands -> ignored; results match the first operation; Busy is high exactly 32 cycles.
REQ-030 RESET at Busy cycle 10 -> next cycle Busy=0, results=0; a subsequent unsigned div 10/3 -> Result1=3, Result2=1.
REQ-031 Back-to-back: Start held high continuously -> operations complete every 33 cycles, with Busy low for exactly one cycle between them.

Source files
------------

// File: rtl/mcycle_unit.sv
// -----------------------------------------------------------------------------
// mcycle_unit
//
// Multi-cycle multiply / divide unit. An accepted request runs for exactly
// WIDTH cycles, one radix-2 iteration per cycle. Multiplication uses shift-add
// and division uses restoring shift-subtract. Signed operations run on
// magnitudes, and the signs are applied in the final iteration cycle.
// Result1/Result2 are written only when an operation completes, so partial
// values never reach the outputs.
//
// Handshake: the unit has no output-valid strobe. Start is looked at only
// while Busy=0 (IDLE). A Start sampled high in IDLE at edge N is accepted.
// Busy is then high for cycles N+1..N+WIDTH. Result1/Result2 become valid in
// cycle N+WIDTH+1, the first IDLE cycle after the operation. In that same
// cycle a new Start can be accepted, so operations can run back to back. All
// inputs are ignored while Busy=1.
//
// Ports:
//   CLK          in   clock, rising edge
//   RESET        in   synchronous, active-high; wins over Start
//   Start        in   request an operation (sampled in IDLE only)
//   MCycleOp     in   00 signed mul, 01 unsigned mul, 10 signed div,
//                     11 unsigned div
//   Operand1     in   multiplicand / dividend
//   Operand2     in   multiplier / divisor
//   Result1      out  mul: product low word;  div: quotient
//   Result2      out  mul: product high word; div: remainder
//   Busy         out  operation in progress
//   dbg_state_o  out  FSM state (0 = IDLE, 1 = COMPUTING)
// -----------------------------------------------------------------------------
module mcycle_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             Start,
  input  logic [1:0]       MCycleOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy,
  output logic             dbg_state_o
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]      LAST  = CW'(WIDTH - 1);
  localparam logic [CW-1:0]      CONE  = CW'(1);
  localparam logic [WIDTH-1:0]   ONE   = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] ONE2  = (2*WIDTH)'(1);

  typedef enum logic {
    S_IDLE      = 1'b0,
    S_COMPUTING = 1'b1
  } state_e;

  state_e state_q, state_d;

  // ---------------------------------------------------------------------------
  // Datapath registers
  //   hi_q : mul -> running high word of the product (bit WIDTH stays 0)
  //          div -> partial remainder
  //   lo_q : mul -> multiplier, shifted right as product low bits come in
  //          div -> dividend, shifted left as quotient bits come in
  //   a_q  : mul -> multiplicand magnitude; div -> divisor magnitude
  // ---------------------------------------------------------------------------
  logic [CW-1:0]    cnt_q,     cnt_d;
  logic             is_div_q,  is_div_d;
  logic             neg_q,     neg_d;      // negate product / quotient
  logic             rneg_q,    rneg_d;     // negate remainder (dividend sign)
  logic             dz_q,      dz_d;       // divide by zero
  logic [WIDTH-1:0] a_q,       a_d;
  logic [WIDTH:0]   hi_q,      hi_d;
  logic [WIDTH-1:0] lo_q,      lo_d;
  logic [WIDTH-1:0] result1_q, result1_d;
  logic [WIDTH-1:0] result2_q, result2_d;

  logic accept;
  logic last_iter;

  assign accept    = (state_q == S_IDLE) && Start;
  assign last_iter = (state_q == S_COMPUTING) && (cnt_q == LAST);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (Start)     state_d = S_COMPUTING;
      S_COMPUTING: if (last_iter) state_d = S_IDLE;
      default:                    state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    Busy        = (state_q == S_COMPUTING);
    dbg_state_o = state_q;
  end

  // ---------------------------------------------------------------------------
  // Operand capture: sign detection and magnitudes
  // ---------------------------------------------------------------------------
  logic             signed_op;
  logic             neg1, neg2;
  logic [WIDTH-1:0] mag1, mag2;

  always_comb begin
    signed_op = ~MCycleOp[0];
    neg1      = signed_op & Operand1[WIDTH-1];
    neg2      = signed_op & Operand2[WIDTH-1];
    mag1      = neg1 ? ((~Operand1) + ONE) : Operand1;
    mag2      = neg2 ? ((~Operand2) + ONE) : Operand2;
  end

  // ---------------------------------------------------------------------------
  // One iteration. Every add/subtract runs WIDTH+1 bits wide, so no carry or
  // borrow is lost.
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             ge;
  logic [WIDTH:0]   iter_hi;
  logic [WIDTH-1:0] iter_lo;

  always_comb begin
    // Multiply: conditionally add the multiplicand, then shift {sum, lo}
    // right by one. The carry out of the add becomes bit WIDTH-1 of hi.
    add_sum = {1'b0, hi_q[WIDTH-1:0]} + (lo_q[0] ? {1'b0, a_q} : '0);

    // Restoring divide: shift the next dividend bit into the remainder, then
    // keep the difference only if it did not underflow. A zero divisor
    // always "succeeds". The quotient becomes all ones, and the remainder
    // collects the dividend unchanged.
    shifted = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
    trial   = shifted - {1'b0, a_q};
    ge      = (shifted >= {1'b0, a_q});

    if (is_div_q) begin
      iter_hi = ge ? trial : shifted;
      iter_lo = {lo_q[WIDTH-2:0], ge};
    end else begin
      iter_hi = {1'b0, add_sum[WIDTH:1]};
      iter_lo = {add_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  // ---------------------------------------------------------------------------
  // Final sign fix-up. It is applied to the output of the last iteration, so
  // completion does not need an extra cycle.
  // ---------------------------------------------------------------------------
  logic [2*WIDTH-1:0] prod_mag;
  logic [2*WIDTH-1:0] prod_fin;
  logic [WIDTH-1:0]   quo_fin;
  logic [WIDTH-1:0]   rem_fin;
  logic [WIDTH-1:0]   fin1;
  logic [WIDTH-1:0]   fin2;

  always_comb begin
    prod_mag = {iter_hi[WIDTH-1:0], iter_lo};
    prod_fin = neg_q ? ((~prod_mag) + ONE2) : prod_mag;

    // Most-negative / -1 needs no special case. The magnitude quotient is
    // 2^(WIDTH-1), and negating it wraps back to the same bit pattern.
    quo_fin = neg_q  ? ((~iter_lo) + ONE) : iter_lo;
    rem_fin = rneg_q ? ((~iter_hi[WIDTH-1:0]) + ONE) : iter_hi[WIDTH-1:0];

    // For x/0, the remainder path already reproduces Operand1 bit for bit.
    // Only the quotient has to be forced to all ones, whatever the signs.
    if (dz_q) begin
      quo_fin = '1;
    end

    fin1 = is_div_q ? quo_fin : prod_fin[WIDTH-1:0];
    fin2 = is_div_q ? rem_fin : prod_fin[2*WIDTH-1:WIDTH];
  end

  // ---------------------------------------------------------------------------
  // Datapath next state
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rneg_d    = rneg_q;
    dz_d      = dz_q;
    a_d       = a_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    result1_d = result1_q;
    result2_d = result2_q;

    if (accept) begin
      cnt_d    = '0;
      is_div_d = MCycleOp[1];
      neg_d    = neg1 ^ neg2;
      rneg_d   = neg1;
      dz_d     = MCycleOp[1] && (Operand2 == '0);
      hi_d     = '0;
      if (MCycleOp[1]) begin
        a_d  = mag2;   // divisor
        lo_d = mag1;   // dividend
      end else begin
        a_d  = mag1;   // multiplicand
        lo_d = mag2;   // multiplier
      end
    end else if (state_q == S_COMPUTING) begin
      cnt_d = cnt_q + CONE;
      hi_d  = iter_hi;
      lo_d  = iter_lo;
      if (last_iter) begin
        result1_d = fin1;
        result2_d = fin2;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rneg_q    <= 1'b0;
      dz_q      <= 1'b0;
      a_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      result1_q <= '0;
      result2_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rneg_q    <= rneg_d;
      dz_q      <= dz_d;
      a_q       <= a_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      result1_q <= result1_d;
      result2_q <= result2_d;
    end
  end

  assign Result1 = result1_q;
  assign Result2 = result2_q;

endmodule
